// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage OTTER pipeline.
// Handles load-use, taken branches and data-memory wait states, with perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic             rs1_used_D,
    input  logic             rs2_used_D,
    input  logic [4:0]       rs1_addr_E,
    input  logic [4:0]       rs2_addr_E,
    input  logic [4:0]       rd_addr_E,
    input  logic [4:0]       rd_addr_M,
    input  logic [4:0]       rd_addr_W,
    input  logic             regWrite_E,
    input  logic             regWrite_M,
    input  logic             regWrite_W,
    input  logic             memRead2_E,
    input  logic             pc_sel_taken_E,
    input  logic             mem_req_M,
    input  logic             mem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    state_t          state;
    logic            pend_flush;
    logic [WC_W-1:0] wait_cnt;
    logic            memwait, loaduse;
    logic            s_f, s_d, s_e, s_m, f_d, f_e, f_w;
    logic [1:0]      fa, fb;

    assign memwait = mem_req_M & ~mem_ready;
    assign loaduse = memRead2_E & (rd_addr_E != 5'd0) &
                     ((rs1_used_D & (rs1_addr_D == rd_addr_E)) |
                      (rs2_used_D & (rs2_addr_D == rd_addr_E)));

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (regWrite_M && rd_addr_M != 5'd0 && rd_addr_M == rs)
            return 2'b01;
        else if (regWrite_W && rd_addr_W != 5'd0 && rd_addr_W == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        {s_f, s_d, s_e, s_m, f_d, f_e, f_w} = '0;
        fa = fwd_sel(rs1_addr_E);
        fb = fwd_sel(rs2_addr_E);
        case (state)
            RUN, MEM_WAIT: begin
                if (memwait) begin
                    {s_f, s_d, s_e, s_m, f_w} = '1;
                end else if (pc_sel_taken_E || (state == MEM_WAIT && pend_flush)) begin
                    // taken redirect kills the decode instruction, so any load-use is moot
                    {f_d, f_e} = '1;
                end else if (loaduse) begin
                    {s_f, s_d, f_e} = '1;
                end
            end
            default: {s_f, s_d, s_e, s_m, f_w} = '1;
        endcase
    end

    // Outputs are forced low for the whole time reset is held.
    assign {stall_F, stall_D, stall_E, stall_M} = RST_N ? {s_f, s_d, s_e, s_m} : 4'b0;
    assign {flush_D, flush_E, flush_W}          = RST_N ? {f_d, f_e, f_w} : 3'b0;
    assign fwd_a_sel = RST_N ? fa : 2'b00;
    assign fwd_b_sel = RST_N ? fb : 2'b00;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= RUN;
            pend_flush <= 1'b0;
            wait_cnt   <= '0;
            mem_err    <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall_F);
            flush_cnt <= flush_cnt + CNT_W'(flush_D);
            case (state)
                RUN: begin
                    if (memwait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                        if (pc_sel_taken_E) pend_flush <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (memwait) begin
                        if (pc_sel_taken_E) pend_flush <= 1'b1;
                        if (wait_cnt >= WC_W'(MEM_TIMEOUT - 1)) begin
                            state   <= ERR;
                            mem_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WC_W'(1);
                        end
                    end else begin
                        state      <= RUN;
                        pend_flush <= 1'b0;
                        wait_cnt   <= '0;
                    end
                end
                default: state <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, forwarding, memory wait,
// timeout and reset behaviour against hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
    logic [4:0]  rd_addr_E, rd_addr_M, rd_addr_W;
    logic        rs1_used_D, rs2_used_D, regWrite_E, regWrite_M, regWrite_W;
    logic        memRead2_E, pc_sel_taken_E, mem_req_M, mem_ready;
    logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rd_addr_E(rd_addr_E), .rd_addr_M(rd_addr_M), .rd_addr_W(rd_addr_W),
        .regWrite_E(regWrite_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
        .memRead2_E(memRead2_E), .pc_sel_taken_E(pc_sel_taken_E),
        .mem_req_M(mem_req_M), .mem_ready(mem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,flush_W}
    function automatic logic [6:0] ctl();
        return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};
    endfunction

    task automatic idle();
        rs1_addr_D = 0; rs2_addr_D = 0; rs1_used_D = 0; rs2_used_D = 0;
        rs1_addr_E = 0; rs2_addr_E = 0; rd_addr_E = 0; rd_addr_M = 0; rd_addr_W = 0;
        regWrite_E = 0; regWrite_M = 0; regWrite_W = 0; memRead2_E = 0;
        pc_sel_taken_E = 0; mem_req_M = 0; mem_ready = 0;
    endtask

    // advance one clock; inputs change 1ns after the edge, checks at +2ns
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST_N = 1'b0;
        // reset held with hazardous inputs: outputs must stay low
        mem_req_M = 1; regWrite_M = 1; rd_addr_M = 7; rs1_addr_E = 7;
        memRead2_E = 1; rd_addr_E = 5; rs2_addr_D = 5; rs2_used_D = 1;
        #2;
        chk("rst_ctl", 32'(ctl()), 32'h0);
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'h0);
        tick(); tick();
        chk("rst_err", 32'(mem_err), 32'h0);
        chk("rst_scnt", stall_cnt, 32'h0);
        idle();
        RST_N = 1'b1;
        tick();

        // load-use on rs2: one-cycle stall_F/stall_D/flush_E
        memRead2_E = 1; rd_addr_E = 5; regWrite_E = 1; rs2_addr_D = 5; rs2_used_D = 1;
        #1 chk("lu_ctl", 32'(ctl()), 32'b1100010);
        tick();
        idle();
        #1 chk("lu_after", 32'(ctl()), 32'h0);
        chk("lu_scnt", stall_cnt, 32'd1);

        // load into x0 never stalls
        memRead2_E = 1; rd_addr_E = 0; rs2_addr_D = 0; rs2_used_D = 1;
        #1 chk("lu_x0", 32'(ctl()), 32'h0);
        // address match but rs1 not used
        rd_addr_E = 5; rs1_addr_D = 5; rs1_used_D = 0; rs2_used_D = 0;
        #1 chk("lu_unused", 32'(ctl()), 32'h0);
        rs1_used_D = 1;
        #1 chk("lu_rs1", 32'(ctl()), 32'b1100010);
        idle();

        // forwarding priority
        rd_addr_M = 7; rd_addr_W = 7; regWrite_M = 1; regWrite_W = 1; rs1_addr_E = 7;
        #1 chk("fwd_a_M", 32'(fwd_a_sel), 32'd1);
        chk("fwd_b_none", 32'(fwd_b_sel), 32'd0);
        regWrite_M = 0;
        #1 chk("fwd_a_W", 32'(fwd_a_sel), 32'd2);
        rs2_addr_E = 7; regWrite_M = 1; rd_addr_M = 3;
        #1 chk("fwd_b_W", 32'(fwd_b_sel), 32'd2);
        rs1_addr_E = 0;
        #1 chk("fwd_a_x0", 32'(fwd_a_sel), 32'd0);
        idle();
        tick();

        // memory wait: 3 stalled cycles, taken in cycle 2, ready in cycle 4
        mem_req_M = 1; mem_ready = 0;
        #1 chk("mw_c1", 32'(ctl()), 32'b1111001);
        tick();
        pc_sel_taken_E = 1;
        #1 chk("mw_c2", 32'(ctl()), 32'b1111001);
        tick();
        pc_sel_taken_E = 0;
        #1 chk("mw_c3", 32'(ctl()), 32'b1111001);
        tick();
        mem_ready = 1;
        #1 chk("mw_c4", 32'(ctl()), 32'b0000110);
        tick();
        idle();
        #1 chk("mw_done", 32'(ctl()), 32'h0);
        chk("mw_scnt", stall_cnt, 32'd4);
        chk("mw_fcnt", flush_cnt, 32'd1);

        // taken branch beats a coincident load-use
        pc_sel_taken_E = 1; memRead2_E = 1; rd_addr_E = 9; rs1_addr_D = 9; rs1_used_D = 1;
        #1 chk("br_lu", 32'(ctl()), 32'b0000110);
        tick();
        idle();
        #1 chk("br_fcnt", flush_cnt, 32'd2);
        chk("br_scnt", stall_cnt, 32'd4);

        // timeout: mem_err appears after the 16th stalled cycle
        mem_req_M = 1; mem_ready = 0;
        for (int i = 0; i < 15; i++) tick();
        #1 chk("to_pre", 32'(mem_err), 32'd0);
        tick();
        #1 chk("to_err", 32'(mem_err), 32'd1);
        chk("to_ctl", 32'(ctl()), 32'b1111001);
        mem_ready = 1;
        tick();
        #1 chk("err_stuck", 32'(ctl()), 32'b1111001);
        chk("err_sticky", 32'(mem_err), 32'd1);

        // asynchronous reset mid-error
        RST_N = 1'b0;
        #1 chk("rst2_ctl", 32'(ctl()), 32'h0);
        chk("rst2_err", 32'(mem_err), 32'd0);
        chk("rst2_scnt", stall_cnt, 32'd0);
        idle();
        tick();
        RST_N = 1'b1;
        tick();
        #1 chk("rst2_run", 32'(ctl()), 32'h0);
        mem_req_M = 1;
        #1 chk("rst2_mw", 32'(ctl()), 32'b1111001);
        mem_ready = 1;
        tick();
        idle();
        #1 chk("rst2_scnt1", stall_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage OTTER pipeline.
- Drives the stall and flush (bubble) controls of the fetch PC and of the F/D, D/E, E/M and M/W pipeline registers.
- Resolves load-use hazards, taken branches/jumps and data-memory wait states; supplies forwarding selects to the execute-stage ALU muxes.
- Keeps stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: max consecutive cycles of data-memory wait before mem_err is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- rs1_addr_D, rs2_addr_D  in  5 each  source register addresses of the instruction in decode.
- rs1_used_D, rs2_used_D  in  1 each  decode instruction actually reads rs1/rs2.
- rs1_addr_E, rs2_addr_E  in  5 each  source register addresses in execute.
- rd_addr_E, rd_addr_M, rd_addr_W  in  5 each  destination register per stage.
- regWrite_E, regWrite_M, regWrite_W  in  1 each  stage writes the register file.
- memRead2_E  in  1  execute instruction is a load.
- pc_sel_taken_E  in  1  branch/jump resolved taken in execute.
- mem_req_M  in  1  memory stage issues a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold the PC / corresponding pipeline register.
- flush_D, flush_E, flush_W  out  1 each  load a bubble into F/D, D/E, M/W.
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 from M, 10 from W, 11 unused.
- mem_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset: while RST_N=0, all stall/flush/fwd outputs are 0. State=RUN; pend_flush=0; wait_cnt=0; mem_err=0; counters=0.
- States: RUN, MEM_WAIT, ERR.

Hazard detection (combinational):
- memwait = mem_req_M & ~mem_ready.
- loaduse = memRead2_E & rd_addr_E!=0 & ((rs1_used_D & rs1_addr_D==rd_addr_E) | (rs2_used_D & rs2_addr_D==rd_addr_E)).

Outputs in RUN, highest priority first:
- memwait: stall_F=stall_D=stall_E=stall_M=1, flush_W=1. Next state MEM_WAIT, wait_cnt=1. If pc_sel_taken_E is also high, set pend_flush=1.
- pc_sel_taken_E: flush_D=flush_E=1, no stalls. A coincident loaduse is ignored because its instruction is flushed.
- loaduse: stall_F=stall_D=1, flush_E=1 for exactly one cycle. The bubble clears the match on the next cycle.
- Otherwise all 0.

MEM_WAIT:
- Same four stalls plus flush_W=1 while memwait.
- pc_sel_taken_E high during the wait sets pend_flush.
- mem_ready=1: release stalls that cycle. Apply flush_D=flush_E=1 if pend_flush | pc_sel_taken_E, then clear pend_flush and return to RUN.
- Otherwise wait_cnt increments. When wait_cnt reaches MEM_TIMEOUT without mem_ready, go to ERR and set mem_err.

ERR:
- All stalls held at 1; flush_W=1.
- Left only by reset; mem_err stays set.

Forwarding (combinational, all states):
- fwd_a_sel=01 if regWrite_M & rd_addr_M!=0 & rd_addr_M==rs1_addr_E.
- Else 10 if regWrite_W & rd_addr_W!=0 & rd_addr_W==rs1_addr_E.
- Else 00. M wins over W. fwd_b_sel is identical using rs2_addr_E.

Counters:
- stall_cnt +1 every cycle stall_F=1.
- flush_cnt +1 every cycle flush_D=1.
- Both wrap modulo 2^CNT_W.

Reset mid-operation:
- Asynchronous assertion drops all outputs in the same cycle and discards pend_flush and wait_cnt.

Test Plan:
- Load to x5 in E (memRead2_E=1, rd_addr_E=5, regWrite_E=1), decode reads x5 via rs2 (rs2_used_D=1) -> one cycle stall_F=stall_D=flush_E=1; next cycle all 0; stall_cnt=1.
- Same load, rd_addr_E=0 or rs1_used_D=0 with a matching address -> no stall.
- rd_addr_M=rd_addr_W=7, both regWrite, rs1_addr_E=7 -> fwd_a_sel=01. Then regWrite_M=0 -> 10. rs1_addr_E=0 -> 00.
- mem_req_M=1, mem_ready=0 for 3 cycles, pc_sel_taken_E pulsed in cycle 2, mem_ready=1 in cycle 4 -> stalls high cycles 1-3. Cycle 4: stalls low, flush_D=flush_E=1. stall_cnt=3, flush_cnt=1.
- mem_ready held 0 with MEM_TIMEOUT=16 -> mem_err rises at cycle 16 after the request and stalls stay high. RST_N pulse -> everything 0, state RUN.
- pc_sel_taken_E and loaduse in the same cycle -> flush_D=flush_E=1, stall_F=0.
